psg_stereo_mixer_dac: RTL and testbench
=======================================

Name: psg_stereo_mixer_dac

Overview:
- Parametrised stereo mixer and 1-bit audio DAC for N sound-generator channels (PSG A/B/C today, extra voices later).
- Sits between the core's per-channel PSG outputs and the board AUDIO_L/AUDIO_R pins.
- Replaces the fixed combinational stereo mux and the two separate DACs.
- Adds a custom per-channel pan mode, mute, master attenuation, sample-strobed serial accumulation and an overrun flag.

Parameters:
NUM_CH, 3, number of input channels (1..16)
CH_BITS, 8, width of each unsigned channel sample
SUM_BITS, CH_BITS+$clog2(NUM_CH), width of the mixed PCM result; derived, must not be overridden smaller

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset
ce_sample  in  1  one-cycle strobe: start mixing the current channel samples
ch_in  in  NUM_CH*CH_BITS  packed unsigned samples, channel 0 in LSBs
mode  in  2  0=mono, 1=ABC, 2=ACB, 3=custom pan
pan_l  in  NUM_CH  custom mode: channel i feeds left
pan_r  in  NUM_CH  custom mode: channel i feeds right
mute  in  NUM_CH  channel i excluded from both sides
vol_shift  in  2  master attenuation, right shift 0..3
pcm_l  out  SUM_BITS  mixed left sample
pcm_r  out  SUM_BITS  mixed right sample
pcm_valid  out  1  one-cycle pulse when pcm_l/pcm_r update
busy  out  1  high while accumulating
overrun  out  1  sticky: ce_sample arrived while busy
audio_l  out  1  sigma-delta bitstream, left
audio_r  out  1  sigma-delta bitstream, right

Behaviour:
- Reset: all outputs 0. FSM to IDLE. Accumulators, latched inputs and both DAC integrators cleared. A reset during ACC aborts the mix; no pcm_valid is emitted.
- FSM states are IDLE, ACC and DONE.
- IDLE, ce_sample=1:
  - Latch ch_in, mute and vol_shift.
  - Resolve mode into pan masks ML/MR and latch them.
  - Clear acc_l/acc_r, set idx=0, go to ACC.
- Mask resolution:
  - mono: ML=MR=all ones.
  - ABC: ML={ch0,ch1}, MR={ch1,ch2}.
  - ACB: ML={ch0,ch2}, MR={ch1,ch2}.
  - custom: ML=pan_l, MR=pan_r.
  - For NUM_CH>3, channels 3+ are centred (both sides) in modes 1/2.
  - Mute is applied afterwards: ML&=~mute, MR&=~mute.
  - Inputs may change freely after the strobe.
- ACC: one channel per cycle.
  - acc_l += ML[idx] ? ch[idx] : 0, and likewise acc_r.
  - idx increments. After idx=NUM_CH-1, go to DONE.
  - busy=1 throughout ACC and DONE.
- DONE:
  - pcm_l <= acc_l >> vol_shift, pcm_r <= acc_r >> vol_shift.
  - pcm_valid=1 for this cycle. Return to IDLE.
  - Latency: strobe at cycle t gives pcm_valid at t+NUM_CH+1. For NUM_CH=3 that is t+4.
- Width: accumulators are SUM_BITS wide. The worst case is NUM_CH*(2^CH_BITS-1), so no overflow and no saturation logic is needed. The shift is logical, zero-fill.
- ce_sample while busy (ACC or DONE): ignored and overrun<=1. overrun is cleared only by reset. A strobe in the same cycle as DONE→IDLE is also ignored.
- pcm_l/pcm_r hold their value between updates.
- DAC, per side, every clk_sys cycle:
  - integ (SUM_BITS+1 bits) <= integ[SUM_BITS-1:0] + pcm.
  - audio = integ[SUM_BITS], registered.
  - Ones density equals pcm/2^SUM_BITS exactly over 2^SUM_BITS cycles.
  - pcm=0 gives a constant 0.
  - The DAC consumes the new pcm the cycle after pcm_valid.

Decomposition:
- Package audio_mix_pkg holds:
  - mode constants MODE_MONO=0, MODE_ABC=1, MODE_ACB=2, MODE_CUSTOM=3;
  - FSM state enum;
  - a function deriving SUM_BITS.
- Sub-module sigma_delta_dac, parameter BITS, instantiated twice, inputs clk_sys/reset/pcm, output bit.

Test Plan:
- NUM_CH=3, CH_BITS=8, A=0x10, B=0x20, C=0x40, mode=0, strobe at t → pcm_l=pcm_r=0x070 with pcm_valid exactly at t+4, busy high t+1..t+4.
- Same samples, mode=1 → pcm_l=0x030, pcm_r=0x060. mode=2 → pcm_l=0x050, pcm_r=0x060.
- mode=3, pan_l=3'b101, pan_r=3'b010, mute=3'b001 → pcm_l=0x040, pcm_r=0x020. With all samples 0xFF, mode=0, vol_shift=0 → 0x2FD; vol_shift=2 → 0x0BF.
- Second ce_sample at t+2 → ignored, single pcm_valid at t+4, overrun=1 and stays 1 after further clean strobes. Reset at t+2 → no pcm_valid, all outputs 0, overrun cleared.
- Hold pcm_l=0x200 (SUM_BITS=10) for 1024 cycles after reset → exactly 512 ones on audio_l. pcm_r=0 → audio_r constantly 0.

Source files
------------

// File: rtl/psg_stereo_mixer_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module : audio_mix_pkg
// Brief  : Shared constants, FSM state type and width helper for the mixer.
// Rev    : 1.0 - initial release
// ============================================================================
package audio_mix_pkg;

    localparam logic [1:0] MODE_MONO   = 2'd0;
    localparam logic [1:0] MODE_ABC    = 2'd1;
    localparam logic [1:0] MODE_ACB    = 2'd2;
    localparam logic [1:0] MODE_CUSTOM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } mix_state_t;

    // Smallest width that holds NUM_CH full-scale samples without overflow.
    function automatic int sum_bits(input int num_ch, input int ch_bits);
        return ch_bits + $clog2(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psg_stereo_mixer_dac_if.sv
`default_nettype none
// ============================================================================
// Module : psg_stereo_mixer_dac_if
// Brief  : Control/sample bundle between the PSG core and the stereo mixer.
// Rev    : 1.0 - initial release
// ============================================================================
interface psg_stereo_mixer_dac_if
    import audio_mix_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int CH_BITS  = 8,
    parameter int SUM_BITS = sum_bits(NUM_CH, CH_BITS)
) ();

    logic                      ce_sample;
    logic [NUM_CH*CH_BITS-1:0] ch_in;
    logic [1:0]                mode;
    logic [NUM_CH-1:0]         pan_l;
    logic [NUM_CH-1:0]         pan_r;
    logic [NUM_CH-1:0]         mute;
    logic [1:0]                vol_shift;
    logic [SUM_BITS-1:0]       pcm_l;
    logic [SUM_BITS-1:0]       pcm_r;
    logic                      pcm_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output ce_sample, ch_in, mode, pan_l, pan_r, mute, vol_shift,
        input  pcm_l, pcm_r, pcm_valid, busy, overrun
    );

    modport slave (
        input  ce_sample, ch_in, mode, pan_l, pan_r, mute, vol_shift,
        output pcm_l, pcm_r, pcm_valid, busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/psg_stereo_mixer_dac_sigma_delta_dac.sv
`default_nettype none
// ============================================================================
// Module : sigma_delta_dac
// Brief  : First-order 1-bit sigma-delta modulator; carry out is the bitstream.
// Rev    : 1.0 - initial release
// ============================================================================
module sigma_delta_dac #(
    parameter int BITS = 10
) (
    input  wire logic            clk_sys,
    input  wire logic            reset,
    input  wire logic [BITS-1:0] pcm,
    output logic                 dac_bit
);

    logic [BITS:0] r_integ;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_integ <= '0;
        end else begin
            r_integ <= {1'b0, r_integ[BITS-1:0]} + {1'b0, pcm};
        end
    end

    assign dac_bit = r_integ[BITS];

endmodule
`default_nettype wire

// File: rtl/psg_stereo_mixer_dac.sv
`default_nettype none
// ============================================================================
// Module : psg_stereo_mixer_dac
// Brief  : Serial N-channel stereo mixer with pan/mute/attenuation and 1-bit DACs.
// Rev    : 1.0 - initial release
// ============================================================================
module psg_stereo_mixer_dac
    import audio_mix_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int CH_BITS  = 8,
    parameter int SUM_BITS = sum_bits(NUM_CH, CH_BITS)
) (
    input  wire logic             clk_sys,
    input  wire logic             reset,
    psg_stereo_mixer_dac_if.slave mix,
    output logic                  audio_l,
    output logic                  audio_r
);

    localparam int                c_IDX_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam [c_IDX_BITS-1:0]   c_LAST_IDX = c_IDX_BITS'(NUM_CH - 1);

    mix_state_t                r_state;
    logic [NUM_CH*CH_BITS-1:0] r_ch;
    logic [NUM_CH-1:0]         r_ml;
    logic [NUM_CH-1:0]         r_mr;
    logic [1:0]                r_vol;
    logic [c_IDX_BITS-1:0]     r_idx;
    logic [SUM_BITS-1:0]       r_acc_l;
    logic [SUM_BITS-1:0]       r_acc_r;
    logic [SUM_BITS-1:0]       r_pcm_l;
    logic [SUM_BITS-1:0]       r_pcm_r;
    logic                      r_pcm_valid;
    logic                      r_busy;
    logic                      r_overrun;

    logic [NUM_CH-1:0]         w_ml;
    logic [NUM_CH-1:0]         w_mr;
    logic [CH_BITS-1:0]        w_ch_cur;
    logic [SUM_BITS-1:0]       w_ch_ext;
    logic [SUM_BITS-1:0]       w_sum_l;
    logic [SUM_BITS-1:0]       w_sum_r;

    // Extra voices beyond A/B/C sit in the centre for the fixed stereo modes.
    always_comb begin
        w_ml = '0;
        w_mr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mix.mode)
                MODE_ABC: begin
                    w_ml[i] = (i != 2);
                    w_mr[i] = (i != 0);
                end
                MODE_ACB: begin
                    w_ml[i] = (i != 1);
                    w_mr[i] = (i != 0);
                end
                MODE_CUSTOM: begin
                    w_ml[i] = mix.pan_l[i];
                    w_mr[i] = mix.pan_r[i];
                end
                default: begin
                    w_ml[i] = 1'b1;
                    w_mr[i] = 1'b1;
                end
            endcase
            w_ml[i] = w_ml[i] & ~mix.mute[i];
            w_mr[i] = w_mr[i] & ~mix.mute[i];
        end
    end

    assign w_ch_cur = r_ch[r_idx*CH_BITS +: CH_BITS];
    assign w_ch_ext = SUM_BITS'(w_ch_cur);
    assign w_sum_l  = r_acc_l + (r_ml[r_idx] ? w_ch_ext : '0);
    assign w_sum_r  = r_acc_r + (r_mr[r_idx] ? w_ch_ext : '0);

    // The final sum is shifted into pcm_l/pcm_r on entry to DONE so that the
    // outputs and pcm_valid are both visible during the DONE cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_ml        <= '0;
            r_mr        <= '0;
            r_vol       <= '0;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_pcm_l     <= '0;
            r_pcm_r     <= '0;
            r_pcm_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_pcm_valid <= 1'b0;
            if (mix.ce_sample && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (mix.ce_sample) begin
                        r_ch    <= mix.ch_in;
                        r_ml    <= w_ml;
                        r_mr    <= w_mr;
                        r_vol   <= mix.vol_shift;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc_l <= w_sum_l;
                    r_acc_r <= w_sum_r;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_pcm_l     <= w_sum_l >> r_vol;
                        r_pcm_r     <= w_sum_r >> r_vol;
                        r_pcm_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mix.pcm_l     = r_pcm_l;
    assign mix.pcm_r     = r_pcm_r;
    assign mix.pcm_valid = r_pcm_valid;
    assign mix.busy      = r_busy;
    assign mix.overrun   = r_overrun;

    sigma_delta_dac #(.BITS(SUM_BITS)) u_dac_l (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pcm     (r_pcm_l),
        .dac_bit (audio_l)
    );

    sigma_delta_dac #(.BITS(SUM_BITS)) u_dac_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pcm     (r_pcm_r),
        .dac_bit (audio_r)
    );

endmodule
`default_nettype wire

// File: tb/tb_psg_stereo_mixer_dac.sv
`default_nettype none
// ============================================================================
// Module : tb_psg_stereo_mixer_dac
// Brief  : Scoreboard bench for the stereo mixer/DAC with a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_psg_stereo_mixer_dac;
    import audio_mix_pkg::*;

    localparam int NUM_CH   = 3;
    localparam int CH_BITS  = 8;
    localparam int SUM_BITS = 10;
    localparam int CHW      = NUM_CH * CH_BITS;
    localparam int LAT      = NUM_CH + 1;

    typedef struct {
        int l;
        int r;
        int t_exp;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic audio_l;
    logic audio_r;

    psg_stereo_mixer_dac_if #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .SUM_BITS(SUM_BITS)) mix ();

    psg_stereo_mixer_dac #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .SUM_BITS(SUM_BITS)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .mix     (mix.slave),
        .audio_l (audio_l),
        .audio_r (audio_r)
    );

    always #5 clk_sys = ~clk_sys;

    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   exp_pcm_l = 0;
    int   exp_pcm_r = 0;
    int   t_start   = -100;
    bit   exp_ovr   = 1'b0;
    bit   chk_en    = 1'b0;
    exp_t q[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    // Reference mix: A is hard left, the "third" voice of the mode hard right,
    // everything else centred; custom uses the pan bits; mute removes a voice.
    task automatic ref_mix(input logic [CHW-1:0] ch, input logic [1:0] md,
                           input logic [NUM_CH-1:0] pl, input logic [NUM_CH-1:0] pr,
                           input logic [NUM_CH-1:0] mu, input logic [1:0] vs,
                           output int l, output int r);
        int sample;
        int pos;
        bit to_l;
        bit to_r;
        l = 0;
        r = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sample = int'(ch[i*CH_BITS +: CH_BITS]);
            pos = 0;
            if (md == MODE_ABC) pos = (i == 0) ? -1 : ((i == 2) ? 1 : 0);
            if (md == MODE_ACB) pos = (i == 0) ? -1 : ((i == 1) ? 1 : 0);
            to_l = (md == MODE_CUSTOM) ? pl[i] : (pos <= 0);
            to_r = (md == MODE_CUSTOM) ? pr[i] : (pos >= 0);
            if (mu[i]) begin
                to_l = 1'b0;
                to_r = 1'b0;
            end
            if (to_l) l += sample;
            if (to_r) r += sample;
        end
        l = l / (1 << vs);
        r = r / (1 << vs);
    endtask

    // Monitor: runs 2 time units after each active edge, away from stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #2;
            if (chk_en) begin
                if (mix.pcm_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_pcm_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("pcm_valid_cycle", cyc, e.t_exp);
                        exp_pcm_l = e.l;
                        exp_pcm_r = e.r;
                    end
                end else if (q.size() > 0 && cyc >= q[0].t_exp) begin
                    check("missing_pcm_valid", 0, 1);
                    e = q.pop_front();
                    exp_pcm_l = e.l;
                    exp_pcm_r = e.r;
                end
                check("pcm_l", int'(mix.pcm_l), exp_pcm_l);
                check("pcm_r", int'(mix.pcm_r), exp_pcm_r);
                check("busy", int'(mix.busy), int'(cyc > t_start && cyc <= t_start + LAT));
                check("overrun", int'(mix.overrun), int'(exp_ovr));
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic strobe(input logic [CHW-1:0] ch, input logic [1:0] md,
                          input logic [NUM_CH-1:0] pl, input logic [NUM_CH-1:0] pr,
                          input logic [NUM_CH-1:0] mu, input logic [1:0] vs,
                          input int el, input int er);
        @(negedge clk_sys);
        mix.ch_in     = ch;
        mix.mode      = md;
        mix.pan_l     = pl;
        mix.pan_r     = pr;
        mix.mute      = mu;
        mix.vol_shift = vs;
        mix.ce_sample = 1'b1;
        if (cyc > t_start && cyc <= t_start + LAT) begin
            exp_ovr = 1'b1;
        end else begin
            t_start = cyc;
            q.push_back('{l: el, r: er, t_exp: cyc + LAT});
        end
        @(negedge clk_sys);
        mix.ce_sample = 1'b0;
        mix.ch_in     = CHW'($urandom);
        mix.mode      = 2'($urandom);
        mix.pan_l     = NUM_CH'($urandom);
        mix.pan_r     = NUM_CH'($urandom);
        mix.mute      = NUM_CH'($urandom);
        mix.vol_shift = 2'($urandom);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk_sys);
        check("drain_timeout", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset     = 1'b1;
        chk_en    = 1'b0;
        q.delete();
        t_start   = -100;
        exp_ovr   = 1'b0;
        exp_pcm_l = 0;
        exp_pcm_r = 0;
        @(posedge clk_sys);
        #2;
        check("rst_pcm_l", int'(mix.pcm_l), 0);
        check("rst_pcm_r", int'(mix.pcm_r), 0);
        check("rst_pcm_valid", int'(mix.pcm_valid), 0);
        check("rst_busy", int'(mix.busy), 0);
        check("rst_overrun", int'(mix.overrun), 0);
        check("rst_audio_l", int'(audio_l), 0);
        check("rst_audio_r", int'(audio_r), 0);
        @(negedge clk_sys);
        reset  = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int ones_l;
        int ones_r;
        mix.ce_sample = 1'b0;
        mix.ch_in     = '0;
        mix.mode      = MODE_MONO;
        mix.pan_l     = '0;
        mix.pan_r     = '0;
        mix.mute      = '0;
        mix.vol_shift = 2'd0;
        do_reset();

        // Directed vectors with hand-derived results.
        strobe(24'h402010, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd0, 'h070, 'h070); wait_done();
        strobe(24'h402010, MODE_ABC,    3'b000, 3'b000, 3'b000, 2'd0, 'h030, 'h060); wait_done();
        strobe(24'h402010, MODE_ACB,    3'b000, 3'b000, 3'b000, 2'd0, 'h050, 'h060); wait_done();
        strobe(24'h402010, MODE_CUSTOM, 3'b101, 3'b010, 3'b001, 2'd0, 'h040, 'h020); wait_done();
        strobe(24'hFFFFFF, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd0, 'h2FD, 'h2FD); wait_done();
        strobe(24'hFFFFFF, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd2, 'h0BF, 'h0BF); wait_done();

        // Strobe two cycles into a mix, then one landing in the DONE cycle.
        strobe(24'h402010, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd0, 'h070, 'h070);
        strobe(24'hFFFFFF, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd0, 'h2FD, 'h2FD);
        wait_done();
        strobe(24'h010203, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd0, 'h006, 'h006);
        gap(2);
        strobe(24'hFFFFFF, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd0, 'h2FD, 'h2FD);
        wait_done();
        strobe(24'h402010, MODE_ABC,    3'b000, 3'b000, 3'b000, 2'd1, 'h018, 'h030); wait_done();

        // Reset in the middle of accumulation: no result may appear.
        strobe(24'hFFFFFF, MODE_MONO,   3'b000, 3'b000, 3'b000, 2'd0, 'h2FD, 'h2FD);
        do_reset();
        gap(6);

        // DAC density: 0x200 of 2^10 on the left, silence on the right.
        strobe(24'h02FFFF, MODE_CUSTOM, 3'b111, 3'b000, 3'b000, 2'd0, 'h200, 'h000);
        wait_done();
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk_sys);
            ones_l += int'(audio_l);
            ones_r += int'(audio_r);
        end
        check("dac_ones_l", ones_l, 512);
        check("dac_ones_r", ones_r, 0);

        // Randomized traffic, including strobes that collide with busy.
        for (int n = 0; n < 60; n++) begin
            logic [CHW-1:0]    ch;
            logic [1:0]        md;
            logic [1:0]        vs;
            logic [NUM_CH-1:0] pl;
            logic [NUM_CH-1:0] pr;
            logic [NUM_CH-1:0] mu;
            int                el;
            int                er;
            ch = CHW'($urandom);
            md = 2'($urandom);
            vs = 2'($urandom);
            pl = NUM_CH'($urandom);
            pr = NUM_CH'($urandom);
            mu = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            ref_mix(ch, md, pl, pr, mu, vs, el, er);
            gap($urandom_range(0, 5));
            strobe(ch, md, pl, pr, mu, vs, el, er);
        end
        wait_done();
        gap(4);
        check("queue_empty_at_end", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
